inst_fetch_queue: RTL and testbench

- Producer side of the instruction path: generates the fetch PC and issues requests on the instruction SRAM-like bus.
- Collects returned words in order and presents {instruction, PC, address-error flag} to the ID-stage decoder through a valid/ready handshake.
- Absorbs bus latency and decoder back-pressure.
- Handles branch/exception redirect, including dropping responses that are still in flight.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_slot_fifo.sv | 74 +++++++
 rtl/inst_fetch_queue.sv | 121 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        filled;
        logic        adel;
    } fetch_entry_t;

    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t FETCH = 1'b0;
    localparam fetch_state_t HALT  = 1'b1;

endpackage

// File: rtl/fetch_slot_fifo.sv
// In-order slot queue: entries are reserved at tail, filled at the oldest unfilled slot and
// retired at head.
module fetch_slot_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         alloc_i,
    input  logic [31:0]  alloc_pc_i,
    input  logic         alloc_adel_i,
    input  logic         fill_i,
    input  logic [31:0]  fill_ins_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         head_filled_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t   entries_q [DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  fill_q;
    logic [PW-1:0]  tail_q;
    logic [PW:0]    count_q;
    logic           skip_fill;

    // A pre-filled (AdEL) slot must not become a fill target when nothing else is pending.
    assign skip_fill = alloc_i && alloc_adel_i && (fill_q == tail_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_i) begin
                entries_q[tail_q] <= '{pc: alloc_pc_i, ins: 32'h0,
                                       filled: alloc_adel_i, adel: alloc_adel_i};
                tail_q <= tail_q + 1'b1;
            end
            if (fill_i) begin
                entries_q[fill_q].ins    <= fill_ins_i;
                entries_q[fill_q].filled <= 1'b1;
            end
            if (fill_i || skip_fill) begin
                fill_q <= fill_q + 1'b1;
            end
            if (pop_i) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + {{PW{1'b0}}, alloc_i} - {{PW{1'b0}}, pop_i};
        end
    end

    assign head_o        = entries_q[head_q];
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == (PW + 1)'(DEPTH));
    assign head_filled_o = !empty_o && head_o.filled;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch PC generator and bus requester feeding the ID stage through an in-order slot queue;
// redirects flush the queue and drop responses still in flight.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic        id_adel,
    input  logic        id_ready
);

    localparam int unsigned CW = $clog2(MAX_OUT) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    fetch_state_t  state_q, state_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    fetch_entry_t  head;
    logic          fifo_full, fifo_empty, head_filled;
    logic [CW:0]   inflight;
    logic          can_req, alloc_req, alloc_adel, fill, drop, pop;

    always_comb begin
        inflight   = {1'b0, outstanding_q} + {1'b0, discard_q};
        can_req    = (state_q == FETCH) && !redirect && (fetch_pc_q[1:0] == 2'b00) &&
                     !fifo_full && (inflight < (CW + 1)'(MAX_OUT));
        alloc_req  = can_req && inst_addr_ok;
        alloc_adel = (state_q == FETCH) && !redirect && (fetch_pc_q[1:0] != 2'b00) &&
                     !fifo_full;
        fill       = inst_data_ok && (discard_q == '0) && !redirect;
        drop       = inst_data_ok && (discard_q != '0) && !redirect;
        pop        = id_valid && id_ready;
    end

    // Held reset keeps the bus request idle even though the request term is combinational.
    assign inst_req  = resetn && can_req;
    assign inst_addr = fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        state_d       = state_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            state_d       = FETCH;
            outstanding_d = '0;
            // Everything in flight becomes discard; a word arriving now is already dropped.
            discard_d     = discard_q + outstanding_q - CW'(inst_data_ok);
        end else begin
            if (alloc_req) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (alloc_adel) begin
                state_d = HALT;
            end
            outstanding_d = outstanding_q + CW'(alloc_req) - CW'(fill);
            discard_d     = discard_q - CW'(drop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q    <= RESET_PC;
            state_q       <= FETCH;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_slot_fifo #(
        .DEPTH (DEPTH)
    ) u_slots (
        .clk           (clk),
        .resetn        (resetn),
        .alloc_i       (alloc_req || alloc_adel),
        .alloc_pc_i    (fetch_pc_q),
        .alloc_adel_i  (alloc_adel),
        .fill_i        (fill),
        .fill_ins_i    (inst_rdata),
        .pop_i         (pop),
        .flush_i       (redirect),
        .head_o        (head),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .head_filled_o (head_filled)
    );

    assign id_valid = head_filled && !redirect;
    assign id_ins   = head.ins;
    assign id_pc    = head.pc;
    assign id_adel  = head.adel;

    a_data_in_flight: assert property (@(posedge clk) disable iff (!resetn)
        inst_data_ok |-> (outstanding_q != '0 || discard_q != '0));

    // A decoder asserting ready while a redirect masks id_valid is tolerated.
    a_ready_with_valid: assert property (@(posedge clk) disable iff (!resetn)
        (id_ready && !redirect) |-> id_valid);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a latency-1 in-order bus responder plus hand-timed steps.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata   = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic        id_adel;
    logic        id_ready;
    logic        rdy_en;
    logic        resp_en;
    logic [31:0] exp_pc;
    logic [31:0] pend [$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Decoder takes the head whenever it is offered; also asserts ready into a redirect cycle.
    assign id_ready = rdy_en & (id_valid | redirect);

    inst_fetch_queue dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ins       (id_ins),
        .id_pc        (id_pc),
        .id_adel      (id_adel),
        .id_ready     (id_ready)
    );

    // Bus responder: returns ~addr, in order, starting the cycle after acceptance.
    always @(posedge clk) begin
        if (!resetn) begin
            pend.delete();
        end else begin
            if (inst_data_ok && pend.size() != 0) void'(pend.pop_front());
            if (inst_req && inst_addr_ok) pend.push_back(inst_addr);
        end
        #1;
        if (resetn && resp_en && pend.size() != 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = ~pend[0];
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        resetn       = 1'b0;
        inst_addr_ok = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        rdy_en       = 1'b1;
        resp_en      = 1'b1;

        // Reset values, then streaming fetch with a latency-1 bus.
        @(negedge clk);
        check("rst_req", inst_req, 32'd0);
        check("rst_valid", id_valid, 32'd0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_ins", id_ins, 32'h0);
        check("rst_adel", id_adel, 32'd0);
        check("rst_addr", inst_addr, 32'hBFC00000);
        resetn = 1'b1;
        #1;
        check("t1_req", inst_req, 32'd1);
        check("t1_addr0", inst_addr, 32'hBFC00000);
        @(negedge clk);
        check("t1_addr1", inst_addr, 32'hBFC00004);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'hBFC00000 + 32'(4 * k);
            check("t1_valid", id_valid, 32'd1);
            check("t1_pc", id_pc, exp_pc);
            check("t1_ins", id_ins, ~exp_pc);
            @(negedge clk);
        end

        // Decoder stalled: queue fills to DEPTH, then drains in order.
        rdy_en = 1'b0;
        apply_reset();
        repeat (10) @(negedge clk);
        check("t2_req_full", inst_req, 32'd0);
        check("t2_addr_full", inst_addr, 32'hBFC00010);
        rdy_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'hBFC00000 + 32'(4 * k);
            check("t2_valid", id_valid, 32'd1);
            check("t2_pc", id_pc, exp_pc);
            check("t2_ins", id_ins, ~exp_pc);
            @(negedge clk);
        end

        // Two requests in flight, then redirect: both late words are dropped.
        rdy_en  = 1'b0;
        resp_en = 1'b0;
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        check("t3_req_maxout", inst_req, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h80001000;
        resp_en     = 1'b1;
        #1;
        check("t3_req_redir", inst_req, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("t3_valid_a", id_valid, 32'd0);
        check("t3_req_disc", inst_req, 32'd0);
        @(negedge clk);
        check("t3_valid_b", id_valid, 32'd0);
        check("t3_req_new", inst_req, 32'd1);
        check("t3_addr_new", inst_addr, 32'h80001000);
        @(negedge clk);
        check("t3_valid_c", id_valid, 32'd0);
        @(negedge clk);
        check("t3_valid_d", id_valid, 32'd1);
        check("t3_pc", id_pc, 32'h80001000);
        check("t3_ins", id_ins, 32'h7FFFEFFF);

        // Misaligned redirect: AdEL entry, HALT until the next redirect.
        redirect    = 1'b1;
        redirect_pc = 32'h80000002;
        #1;
        check("t4_valid_redir", id_valid, 32'd0);
        check("t4_req_redir", inst_req, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("t4_req_mis", inst_req, 32'd0);
        check("t4_valid_a", id_valid, 32'd0);
        @(negedge clk);
        check("t4_valid_b", id_valid, 32'd1);
        check("t4_adel", id_adel, 32'd1);
        check("t4_pc", id_pc, 32'h80000002);
        check("t4_ins", id_ins, 32'h0);
        check("t4_req_halt", inst_req, 32'd0);
        rdy_en = 1'b1;
        @(negedge clk);
        check("t4_valid_popped", id_valid, 32'd0);
        repeat (3) @(negedge clk);
        check("t4_req_still_halt", inst_req, 32'd0);
        check("t4_valid_still", id_valid, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h80000000;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("t4_req_resume", inst_req, 32'd1);
        check("t4_addr_resume", inst_addr, 32'h80000000);
        @(negedge clk);
        @(negedge clk);
        check("t4_valid_resume", id_valid, 32'd1);
        check("t4_pc_resume", id_pc, 32'h80000000);
        check("t4_ins_resume", id_ins, 32'h7FFFFFFF);
        check("t4_adel_resume", id_adel, 32'd0);

        // Redirect coinciding with data_ok and id_ready, one more word still in flight.
        rdy_en  = 1'b0;
        resp_en = 1'b0;
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        resp_en = 1'b1;
        @(negedge clk);
        resp_en = 1'b0;
        @(negedge clk);
        check("t5_head_valid", id_valid, 32'd1);
        check("t5_head_pc", id_pc, 32'hBFC00000);
        check("t5_req_third", inst_req, 32'd1);
        check("t5_addr_third", inst_addr, 32'hBFC00008);
        resp_en = 1'b1;
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h80002000;
        rdy_en      = 1'b1;
        resp_en     = 1'b0;
        #1;
        check("t5_dok_in_redir", inst_data_ok, 32'd1);
        check("t5_valid_redir", id_valid, 32'd0);
        check("t5_req_redir", inst_req, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        resp_en  = 1'b1;
        #1;
        check("t5_req_new", inst_req, 32'd1);
        check("t5_addr_new", inst_addr, 32'h80002000);
        check("t5_valid_a", id_valid, 32'd0);
        @(negedge clk);
        check("t5_valid_b", id_valid, 32'd0);
        check("t5_req_disc", inst_req, 32'd0);
        @(negedge clk);
        check("t5_valid_c", id_valid, 32'd0);
        check("t5_req_drained", inst_req, 32'd1);
        check("t5_addr_next", inst_addr, 32'h80002004);
        @(negedge clk);
        check("t5_valid_d", id_valid, 32'd1);
        check("t5_pc", id_pc, 32'h80002000);
        check("t5_ins", id_ins, 32'h7FFFDFFF);

        // Asynchronous reset mid-burst with two requests outstanding.
        rdy_en  = 1'b0;
        resp_en = 1'b0;
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        check("t6_req_maxout", inst_req, 32'd0);
        check("t6_addr_before", inst_addr, 32'hBFC00008);
        resetn = 1'b0;
        #1;
        check("t6_rst_req", inst_req, 32'd0);
        check("t6_rst_addr", inst_addr, 32'hBFC00000);
        check("t6_rst_valid", id_valid, 32'd0);
        check("t6_rst_pc", id_pc, 32'h0);
        check("t6_rst_ins", id_ins, 32'h0);
        check("t6_rst_adel", id_adel, 32'd0);
        @(negedge clk);
        resetn  = 1'b1;
        resp_en = 1'b1;
        #1;
        check("t6_req_restart", inst_req, 32'd1);
        check("t6_addr_restart", inst_addr, 32'hBFC00000);
        @(negedge clk);
        @(negedge clk);
        check("t6_valid", id_valid, 32'd1);
        check("t6_pc", id_pc, 32'hBFC00000);
        check("t6_ins", id_ins, 32'h403FFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
